// File: rtl/latch_load_arbiter.sv
// latch_load_arbiter: shares one latch bank among requesters with a setup/enable/hold sequence (LATCH_ARB_FIXED_PRIO_EN selects fixed priority)
module latch_load_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic                     o_latch_en,
  output logic [WIDTH-1:0]         o_latch_d
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD} state_t;
  state_t             r_state, w_next;
  logic [3:0]         r_cnt;
  logic [IW-1:0]      w_win, w_start;
  logic               w_hit;
  int                 w_j;
  logic [NUM_REQ-1:0] r_grant, r_done;
  logic               r_latch_en;
  logic [WIDTH-1:0]   r_data_q;
`ifdef LATCH_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IW-1:0] r_ptr, r_win;
  assign w_start = r_ptr;
  // Remember the winner and move the search start just past it when the load completes.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_win <= '0;
    end else begin
      if (r_state == S_IDLE && w_hit) r_win <= w_win;
      if (r_state == S_HOLD) r_ptr <= (r_win == IW'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
    end
`endif
  // Search from the start index upward with wrap; scanning downward lets the nearest hit win last.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_j   = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_j = (int'(w_start) + k) % NUM_REQ;
      if (i_req[w_j[IW-1:0]]) begin
        w_hit = 1'b1;
        w_win = w_j[IW-1:0];
      end
    end
  end
  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // Next state: SETUP and HOLD last one cycle, ENABLE runs until the counter hits zero.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_hit ? S_SETUP : S_IDLE;
      S_SETUP:  w_next = S_ENABLE;
      S_ENABLE: w_next = (r_cnt == 4'd0) ? S_HOLD : S_ENABLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // Registered latch pins, grant, done and counter so the enable never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_latch_en <= 1'b0;
      r_done     <= '0;
      r_grant    <= '0;
      r_data_q   <= '0;
      r_cnt      <= '0;
    end else begin
      r_latch_en <= (w_next == S_ENABLE);
      r_done     <= (w_next == S_HOLD) ? r_grant : '0;
      if (r_state == S_IDLE && w_hit) begin
        r_grant  <= NUM_REQ'(1) << w_win;
        r_data_q <= i_req_data[int'(w_win)*WIDTH +: WIDTH];
      end else if (r_state == S_HOLD) r_grant <= '0;
      r_cnt <= (r_state == S_SETUP) ? 4'(HOLD_CYCLES-1) :
               (r_state == S_ENABLE && r_cnt != 4'd0) ? r_cnt - 1'b1 : r_cnt;
    end
  assign o_grant    = r_grant;
  assign o_done     = r_done;
  assign o_busy     = (r_state != S_IDLE);
  assign o_latch_en = r_latch_en;
  assign o_latch_d  = r_data_q;
endmodule

// File: tb/tb_latch_load_arbiter.sv
// tb_latch_load_arbiter: random and directed loads on three hold lengths against a transaction-level model
module tb_latch_load_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ND = 3;
  function automatic int hc(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   grant [ND];
  logic [N-1:0]   done [ND];
  logic           busy [ND];
  logic           len [ND];
  logic [W-1:0]   ld [ND];
  int n_tests = 0;
  int n_fail = 0;
  int t [ND];
  int win [ND];
  int ptr [ND];
  logic [W-1:0] dq [ND];
  always #5 clk = ~clk;
  for (genvar g = 0; g < ND; g++) begin : g_dut
    latch_load_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(hc(g))) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
      .o_grant(grant[g]), .o_done(done[g]), .o_busy(busy[g]),
      .o_latch_en(len[g]), .o_latch_d(ld[g]));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      t[d] = 0; win[d] = 0; ptr[d] = 0; dq[d] = '0;
    end
  endtask
  // Phase t: 0 idle, 1 setup, 2..H+1 enable, H+2 hold with done.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (t[d] == 0) begin
        for (int k = N-1; k >= 0; k--)
          if (req[(ptr[d]+k)%N]) win[d] = (ptr[d]+k)%N;
        if (|req) begin
          t[d] = 1;
          dq[d] = req_data[win[d]*W +: W];
        end
      end else if (t[d] == hc(d)+2) begin
        t[d] = 0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
        ptr[d] = (win[d]+1) % N;
`endif
      end else t[d]++;
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d grant", d), 32'(grant[d]), (t[d] != 0) ? 32'(1) << win[d] : 32'd0);
      check($sformatf("d%0d done", d), 32'(done[d]), (t[d] == hc(d)+2) ? 32'(1) << win[d] : 32'd0);
      check($sformatf("d%0d busy", d), 32'(busy[d]), 32'(t[d] != 0));
      check($sformatf("d%0d latch_en", d), 32'(len[d]), 32'(t[d] >= 2 && t[d] <= hc(d)+1));
      check($sformatf("d%0d latch_d", d), 32'(ld[d]), 32'(dq[d]));
    end
  endtask
  task automatic cyc(input logic [N-1:0] r, input logic [N*W-1:0] dat);
    req = r;
    req_data = dat;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
    repeat (20) cyc(4'b0000, {8'h00, 8'h5A, 8'h00, 8'h00});
    repeat (8*18) cyc(4'b1111, $urandom());
    repeat (20) cyc(4'b0000, $urandom());
    cyc(4'b0010, {8'h11, 8'h22, 8'h3C, 8'h44});
    cyc(4'b0010, {8'h11, 8'h22, 8'h3C, 8'h44});
    repeat (20) cyc(4'b0000, {8'h11, 8'h22, 8'hFF, 8'h44});
    cyc(4'b0100, $urandom());
    repeat (3) cyc(4'b1111, $urandom());
    async_reset();
    repeat (12) cyc(4'b1111, $urandom());
    repeat (20) cyc(4'b0000, $urandom());
    cyc(4'b0001, $urandom());
    cyc(4'b0001, $urandom());
    repeat (25) cyc(4'b1000, $urandom());
    repeat (800) begin
      cyc(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom()), $urandom());
      if ($urandom_range(0, 99) == 0) async_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
